// File: rtl/data_mem_pkg.sv
// Shared definitions for the MEM-stage data memory.
//   SIZE_*        : encodings of the req_size field
//   state_t       : controller states (CLEAR runs after every reset, RUN serves requests)
//   access_bytes  : number of bytes touched by an access of a given size
package data_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // The reserved size is flagged as an error elsewhere; it reports 4 here
    // so the range check stays conservative.
    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load alignment and extension (combinational).
//   bytes_i    : {mem[A], mem[A+1], mem[A+2], mem[A+3]} (big-endian order)
//   size_i     : access size (byte / half / word)
//   unsigned_i : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   data_o     : right-justified, extended 32-bit load value
module load_extend
    import data_mem_pkg::*;
(
    input  logic [31:0] bytes_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic ext_bit;

    // Byte and half loads both start at mem[A], so their sign bit is bit 31.
    assign ext_bit = ~unsigned_i & bytes_i[31];

    always_comb begin
        data_o = bytes_i;
        case (size_i)
            SIZE_BYTE: data_o = {{24{ext_bit}}, bytes_i[31:24]};
            SIZE_HALF: data_o = {{16{ext_bit}}, bytes_i[31:16]};
            default:   data_o = bytes_i;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed, big-endian data memory for the MIPS MEM stage.
// After every reset the array is zero-filled by an internal clear sequence;
// requests are then accepted every cycle and answered with a fixed latency of
// two edges (accept at edge N, response visible after edge N+1).
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (ready only once the clear is done)
//   req_write           : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned        : loads only, 1 = zero-extend
//   req_addr            : byte address
//   req_wdata           : right-justified store data
//   rsp_valid           : one-cycle response strobe per accepted request
//   rsp_rdata           : load result (0 for stores and errors)
//   rsp_error           : misaligned, out-of-range or reserved size
//   busy                : clear sequence in progress
module data_memory_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH_BYTES         = 256,
    parameter int ADDR_WIDTH          = 32,
    parameter int CLR_WORDS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy
);

    localparam int IDX_W      = $clog2(DEPTH_BYTES);
    localparam int AW1        = ADDR_WIDTH + 1;
    localparam int CLR_CYCLES = DEPTH_BYTES / (4 * CLR_WORDS_PER_CYCLE);
    localparam int CNT_W      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_CYCLES - 1);

    // The array has no reset; only the clear sequence zeroes it.
    logic [7:0] mem_q [DEPTH_BYTES];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             clr_en;
    logic             accept;

    // ---------------- Clear / run controller ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ready/busy follow the registered state, so they change on the edge
    // after the last clear write.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_en    = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                clr_en    = 1'b1;
                clr_cnt_d = clr_cnt_q + CNT_W'(1);
                if (clr_cnt_q == CNT_LAST) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN: begin
                req_ready = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign accept = req_valid && req_ready;

    // ---------------- Request decode ----------------
    logic [AW1-1:0]   last_byte;
    logic             misalign;
    logic             out_of_range;
    logic             req_err;
    logic [IDX_W-1:0] idx0, idx1, idx2, idx3;

    // One extra bit so that addresses near the top of the space cannot wrap
    // back into range.
    assign last_byte    = {1'b0, req_addr} + AW1'(access_bytes(req_size)) - AW1'(1);
    assign out_of_range = (last_byte >= AW1'(DEPTH_BYTES));
    assign misalign     = ((req_size == SIZE_HALF) && req_addr[0]) ||
                          ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign req_err      = misalign || out_of_range || (req_size == SIZE_RSVD);

    assign idx0 = req_addr[IDX_W-1:0];
    assign idx1 = idx0 + IDX_W'(1);
    assign idx2 = idx0 + IDX_W'(2);
    assign idx3 = idx0 + IDX_W'(3);

    // ---------------- Array write: clear or store at the accept edge ----------------
    always_ff @(posedge clk) begin
        if (clr_en) begin
            for (int w = 0; w < CLR_WORDS_PER_CYCLE; w++) begin
                for (int b = 0; b < 4; b++) begin
                    mem_q[IDX_W'((int'(clr_cnt_q) * CLR_WORDS_PER_CYCLE + w) * 4 + b)] <= 8'h00;
                end
            end
        end else if (accept && req_write && !req_err) begin
            case (req_size)
                SIZE_BYTE: begin
                    mem_q[idx0] <= req_wdata[7:0];
                end
                SIZE_HALF: begin
                    mem_q[idx0] <= req_wdata[15:8];
                    mem_q[idx1] <= req_wdata[7:0];
                end
                default: begin
                    mem_q[idx0] <= req_wdata[31:24];
                    mem_q[idx1] <= req_wdata[23:16];
                    mem_q[idx2] <= req_wdata[15:8];
                    mem_q[idx3] <= req_wdata[7:0];
                end
            endcase
        end
    end

    // ---------------- Stage p0: accepted request ----------------
    logic             vld_p0_q;
    logic             write_p0_q;
    logic [1:0]       size_p0_q;
    logic             uns_p0_q;
    logic             err_p0_q;
    logic [IDX_W-1:0] idx_p0_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0_q <= 1'b0;
        end else begin
            vld_p0_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0_q <= req_write;
            size_p0_q  <= req_size;
            uns_p0_q   <= req_unsigned;
            err_p0_q   <= req_err;
            idx_p0_q   <= idx0;
        end
    end

    // The array is read one edge after acceptance, so a store accepted on the
    // previous edge is already visible to the following load.
    logic [31:0] rd_bytes;
    logic [31:0] ext_data;

    assign rd_bytes = {mem_q[idx_p0_q],
                       mem_q[idx_p0_q + IDX_W'(1)],
                       mem_q[idx_p0_q + IDX_W'(2)],
                       mem_q[idx_p0_q + IDX_W'(3)]};

    load_extend u_load_extend (
        .bytes_i    (rd_bytes),
        .size_i     (size_p0_q),
        .unsigned_i (uns_p0_q),
        .data_o     (ext_data)
    );

    // ---------------- Stage p1: response ----------------
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= vld_p0_q;
            rsp_error_q <= vld_p0_q && err_p0_q;
            rsp_rdata_q <= (vld_p0_q && !err_p0_q && !write_p0_q) ? ext_data : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
